writeback_stage: RTL

- Final pipeline stage. Arbitrates between the ALU result channel and the load/store unit (LSU) load-return channel.
- Formats load data (byte/half/word, signed/unsigned).
- Drives the register file write port (write enable, destination, data) through one registered cycle.
- Maintains the retired-instruction counter and a load-format error pulse.

---
 rtl/riscv_pkg.sv | 10 +
 rtl/writeback_stage_if.sv | 22 ++
 rtl/load_formatter.sv | 25 ++
 rtl/writeback_stage.sv | 78 +++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared datapath widths and load funct3 encodings
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int REG_ADDR_W = 5;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
endpackage

// File: rtl/writeback_stage_if.sv
// writeback_stage_if: ALU result and LSU load-return valid/ready channels
interface writeback_stage_if;
  import riscv_pkg::*;
  logic                  alu_valid;
  logic                  alu_ready;
  logic [REG_ADDR_W-1:0] alu_rd;
  logic [XLEN-1:0]       alu_data;
  logic                  lsu_valid;
  logic                  lsu_ready;
  logic [REG_ADDR_W-1:0] lsu_rd;
  logic [XLEN-1:0]       lsu_data;
  logic [2:0]            lsu_funct3;
  logic [1:0]            lsu_addr_lo;
  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data, lsu_funct3, lsu_addr_lo,
    input  alu_ready, lsu_ready
  );
  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data, lsu_funct3, lsu_addr_lo,
    output alu_ready, lsu_ready
  );
endinterface

// File: rtl/load_formatter.sv
// load_formatter: lane select and sign/zero extension of a raw load word
module load_formatter
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] data_i,
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      addr_lo_i,
  output logic [XLEN-1:0] data_o,
  output logic            err_o
);
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  assign byte_v = data_i[{addr_lo_i, 3'b000} +: 8];
  assign half_v = addr_lo_i[1] ? data_i[31:16] : data_i[15:0];
  // Halves need an even offset, words an aligned one; unlisted funct3 codes are illegal
  always_comb begin
    err_o  = (funct3_i == F3_LH || funct3_i == F3_LHU) ? addr_lo_i[0] :
             (funct3_i == F3_LW) ? |addr_lo_i :
             (funct3_i == F3_LB || funct3_i == F3_LBU) ? 1'b0 : 1'b1;
    data_o = (funct3_i == F3_LB)  ? {{24{byte_v[7]}}, byte_v} :
             (funct3_i == F3_LBU) ? {24'b0, byte_v} :
             (funct3_i == F3_LH)  ? {{16{half_v[15]}}, half_v} :
             (funct3_i == F3_LHU) ? {16'b0, half_v} : data_i;
  end
endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: ALU/LSU arbitration with starvation guard, registered regfile write, instret
module writeback_stage
  import riscv_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int INSTRET_W    = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  writeback_stage_if.slave      bus,
  output logic                  reg_write_en,
  output logic [REG_ADDR_W-1:0] reg_write_dest,
  output logic [XLEN-1:0]       reg_write_data,
  output logic                  load_err,
  output logic [INSTRET_W-1:0]  instret
);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0]            starve_q, starve_d;
  logic                  en_q, en_d, err_q, err_d;
  logic [REG_ADDR_W-1:0] dest_q, dest_d, rd;
  logic [XLEN-1:0]       data_q, data_d, wdata, fmt_data;
  logic [INSTRET_W-1:0]  instret_q, instret_d;
  logic                  fmt_err, alu_fire, lsu_fire, bad, retire;

  load_formatter u_fmt (
    .data_i    (bus.lsu_data),
    .funct3_i  (bus.lsu_funct3),
    .addr_lo_i (bus.lsu_addr_lo),
    .data_o    (fmt_data),
    .err_o     (fmt_err)
  );

  // ALU takes the slot when alone, or under contention once it has lost LIMIT times in a row
  assign bus.alu_ready = !bus.lsu_valid || (bus.alu_valid && starve_q == LIMIT);
  assign bus.lsu_ready = !(bus.alu_valid && bus.alu_ready);
  assign alu_fire      = bus.alu_valid && bus.alu_ready;
  assign lsu_fire      = bus.lsu_valid && bus.lsu_ready;
  assign bad           = lsu_fire && fmt_err;
  assign retire        = alu_fire || (lsu_fire && !fmt_err);
  assign rd            = alu_fire ? bus.alu_rd : bus.lsu_rd;
  assign wdata         = alu_fire ? bus.alu_data : fmt_data;

  // Next state: a bad load only raises load_err; dest/data hold unless a legal beat retires
  always_comb begin
    starve_d  = alu_fire ? 4'd0 :
                (lsu_fire && bus.alu_valid && starve_q != LIMIT) ? starve_q + 4'd1 : starve_q;
    en_d      = retire && rd != '0;
    err_d     = bad;
    dest_d    = retire ? rd : dest_q;
    data_d    = retire ? wdata : data_q;
    instret_d = instret_q + INSTRET_W'(retire);
  end

  // State registers; reset drops any in-flight write immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_q  <= '0;
      en_q      <= 1'b0;
      err_q     <= 1'b0;
      dest_q    <= '0;
      data_q    <= '0;
      instret_q <= '0;
    end else begin
      starve_q  <= starve_d;
      en_q      <= en_d;
      err_q     <= err_d;
      dest_q    <= dest_d;
      data_q    <= data_d;
      instret_q <= instret_d;
    end
  end

  assign reg_write_en   = en_q;
  assign reg_write_dest = dest_q;
  assign reg_write_data = data_q;
  assign load_err       = err_q;
  assign instret        = instret_q;
endmodule
